mem_stage: RTL and testbench

Memory-access pipeline stage of the five-stage CPU, between the EX/MEM register and the write-back stage. It issues loads and stores to the data memory over a req/ack handshake and stalls the upstream pipeline while an access is outstanding. It aligns and extends load data, then registers the MEM/WB pipeline values that the write-back stage consumes directly.

---
 rtl/mem_stage.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory loads/stores over a req/ack handshake,
// stalls upstream while an access is outstanding, and registers the MEM/WB values.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [1:0]  size,
    input  logic        load_signed,
    input  logic [31:0] Aluout,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_stall,
    output logic        d_req,
    output logic        d_we,
    output logic [31:0] d_addr,
    output logic [31:0] d_wdata,
    output logic [3:0]  d_wstrb,
    input  logic        d_ack,
    input  logic [31:0] d_rdata,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [31:0] Aluout_out,
    output logic [31:0] rdata_out,
    output logic [4:0]  rd_out,
    output logic        addr_err,
    output logic [31:0] bad_addr
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  lsize_q, lsize_d, loff_q, loff_d;
    logic        lsigned_q, lsigned_d;
    logic        hold_m2r_q, hold_m2r_d, hold_rw_q, hold_rw_d;
    logic [31:0] hold_alu_q, hold_alu_d;
    logic [4:0]  hold_rd_q, hold_rd_d;
    logic        wb_m2r_q, wb_m2r_d, wb_rw_q, wb_rw_d;
    logic [31:0] wb_alu_q, wb_alu_d, wb_rdata_q, wb_rdata_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        err_q, err_d;
    logic [31:0] bad_q, bad_d;

    logic        memop, misaligned, stall;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign memop      = in_valid & (MemRead | MemWrite);
    assign misaligned = (size == 2'b01) ? Aluout[0] : (size[1] & (Aluout[1:0] != 2'b00));

    // Alignment and extension of the returned word, using the fields latched at issue.
    always_comb begin
        ld_byte = 8'(d_rdata >> {loff_q, 3'b000});
        ld_half = loff_q[1] ? d_rdata[31:16] : d_rdata[15:0];
        case (lsize_q)
            2'b00:   ld_data = {{24{lsigned_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{lsigned_q & ld_half[15]}}, ld_half};
            default: ld_data = d_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        lsize_d    = lsize_q;
        loff_d     = loff_q;
        lsigned_d  = lsigned_q;
        hold_m2r_d = hold_m2r_q;
        hold_rw_d  = hold_rw_q;
        hold_alu_d = hold_alu_q;
        hold_rd_d  = hold_rd_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        wb_alu_d   = wb_alu_q;
        wb_rdata_d = wb_rdata_q;
        wb_rd_d    = wb_rd_q;
        err_d      = 1'b0;
        bad_d      = bad_q;
        stall      = 1'b0;

        case (state_q)
            StIdle: begin
                if (memop && !misaligned) begin
                    stall      = 1'b1;
                    state_d    = StWait;
                    req_d      = 1'b1;
                    we_d       = MemWrite;
                    addr_d     = {Aluout[31:2], 2'b00};
                    lsize_d    = size;
                    loff_d     = Aluout[1:0];
                    lsigned_d  = load_signed;
                    hold_m2r_d = MemtoReg;
                    hold_rw_d  = RegWrite;
                    hold_alu_d = Aluout;
                    hold_rd_d  = rd;
                    if (MemWrite) begin
                        case (size)
                            2'b00: begin
                                wdata_d = {4{wdata[7:0]}};
                                wstrb_d = 4'b0001 << Aluout[1:0];
                            end
                            2'b01: begin
                                wdata_d = {2{wdata[15:0]}};
                                wstrb_d = Aluout[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                wdata_d = wdata;
                                wstrb_d = 4'b1111;
                            end
                        endcase
                    end else begin
                        wdata_d = 32'h0;
                        wstrb_d = 4'b0000;
                    end
                    wb_m2r_d   = 1'b0;
                    wb_rw_d    = 1'b0;
                    wb_alu_d   = 32'h0;
                    wb_rdata_d = 32'h0;
                    wb_rd_d    = 5'd0;
                end else begin
                    // Plain ALU op, bubble, or misaligned access that is squashed here.
                    wb_m2r_d   = MemtoReg;
                    wb_rw_d    = RegWrite & in_valid & ~memop;
                    wb_alu_d   = Aluout;
                    wb_rdata_d = 32'h0;
                    wb_rd_d    = rd;
                    if (memop) begin
                        err_d = 1'b1;
                        bad_d = Aluout;
                    end
                end
            end
            StWait: begin
                stall = ~d_ack;
                if (d_ack) begin
                    state_d    = StIdle;
                    req_d      = 1'b0;
                    wb_m2r_d   = hold_m2r_q;
                    wb_rw_d    = hold_rw_q;
                    wb_alu_d   = hold_alu_q;
                    wb_rdata_d = we_q ? 32'h0 : ld_data;
                    wb_rd_d    = hold_rd_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            lsize_q    <= 2'b00;
            loff_q     <= 2'b00;
            lsigned_q  <= 1'b0;
            hold_m2r_q <= 1'b0;
            hold_rw_q  <= 1'b0;
            hold_alu_q <= 32'h0;
            hold_rd_q  <= 5'd0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_alu_q   <= 32'h0;
            wb_rdata_q <= 32'h0;
            wb_rd_q    <= 5'd0;
            err_q      <= 1'b0;
            bad_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            lsize_q    <= lsize_d;
            loff_q     <= loff_d;
            lsigned_q  <= lsigned_d;
            hold_m2r_q <= hold_m2r_d;
            hold_rw_q  <= hold_rw_d;
            hold_alu_q <= hold_alu_d;
            hold_rd_q  <= hold_rd_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
            bad_q      <= bad_d;
        end
    end

    assign mem_stall    = reset & stall;
    assign d_req        = req_q;
    assign d_we         = we_q;
    assign d_addr       = addr_q;
    assign d_wdata      = wdata_q;
    assign d_wstrb      = wstrb_q;
    assign MemtoReg_out = wb_m2r_q;
    assign RegWrite_out = wb_rw_q;
    assign Aluout_out   = wb_alu_q;
    assign rdata_out    = wb_rdata_q;
    assign rd_out       = wb_rd_q;
    assign addr_err     = err_q;
    assign bad_addr     = bad_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by randomized
// operations checked against a word-array memory model and arithmetic load/store rules.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, MemRead, MemWrite, MemtoReg, RegWrite, load_signed;
    logic [1:0]  size;
    logic [31:0] Aluout, wdata;
    logic [4:0]  rd;
    logic        mem_stall, d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        MemtoReg_out, RegWrite_out;
    logic [31:0] Aluout_out, rdata_out;
    logic [4:0]  rd_out;
    logic        addr_err;
    logic [31:0] bad_addr;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [256];

    mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .size(size), .load_signed(load_signed),
        .Aluout(Aluout), .wdata(wdata), .rd(rd), .mem_stall(mem_stall), .d_req(d_req),
        .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_ack(d_ack),
        .d_rdata(d_rdata), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
        .Aluout_out(Aluout_out), .rdata_out(rdata_out), .rd_out(rd_out),
        .addr_err(addr_err), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        size = 0; load_signed = 0; Aluout = 0; wdata = 0; rd = 0;
    endtask

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] sz, input bit sgn);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (word >> ((a % 4) * 8)) & 32'hFF;
            if (sgn && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (word >> (((a % 4) / 2) * 16)) & 32'hFFFF;
            if (sgn && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = word;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return ((a % 4) < 2) ? 4'd3 : 4'd12;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
        return w;
    endfunction

    // Assumes the caller is just after a rising edge; leaves the bench in the same phase.
    task automatic alu_op(input logic [31:0] a, input logic [4:0] dst, input bit rw,
                          input bit vld);
        drive_idle();
        in_valid = vld; RegWrite = rw; Aluout = a; rd = dst;
        d_ack = 1'b1;  // must be ignored while idle
        #1 check("alu_stall", mem_stall, 0);
        @(posedge clk); #1;
        d_ack = 1'b0;
        check("alu_out", Aluout_out, a);
        check("alu_rd", rd_out, dst);
        check("alu_rw", RegWrite_out, rw & vld);
        check("alu_rdata", rdata_out, 0);
        check("alu_req", d_req, 0);
    endtask

    task automatic mem_op(input bit re, input bit we, input logic [1:0] sz, input bit sgn,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] dst,
                          input bit rw, input bit m2r, input int delay);
        bit          mis;
        int          stalls;
        int          idx;
        logic [31:0] exp_rd, wrep;
        logic [3:0]  strb;
        mis  = is_mis(sz, a);
        idx  = int'(a[9:2]);
        strb = we ? model_strb(sz, a) : 4'd0;
        wrep = model_wdata(sz, wd);
        drive_idle();
        in_valid = 1; MemRead = re; MemWrite = we; size = sz; load_signed = sgn;
        Aluout = a; wdata = wd; rd = dst; RegWrite = rw; MemtoReg = m2r;
        #1 check("issue_stall", mem_stall, mis ? 0 : 1);
        @(posedge clk); #1;
        if (mis) begin
            drive_idle();
            check("mis_req", d_req, 0);
            check("mis_err", addr_err, 1);
            check("mis_bad", bad_addr, a);
            check("mis_rw", RegWrite_out, 0);
            check("mis_alu", Aluout_out, a);
            @(posedge clk); #1;
            check("mis_pulse", addr_err, 0);
            check("mis_hold", bad_addr, a);
            return;
        end
        stalls = 1;
        check("req_up", d_req, 1);
        check("req_addr", d_addr, a & 32'hFFFFFFFC);
        check("req_we", d_we, we);
        check("req_strb", d_wstrb, strb);
        if (we) check("req_wdata", d_wdata, wrep);
        check("bubble_rw", RegWrite_out, 0);
        for (int i = 0; i < delay; i++) begin
            d_ack = 0;
            #1 check("wait_stall", mem_stall, 1);
            stalls++;
            @(posedge clk); #1;
            check("wait_req", d_req, 1);
            check("wait_addr", d_addr, a & 32'hFFFFFFFC);
        end
        d_ack = 1;
        d_rdata = we ? $urandom : mem[idx];
        exp_rd = we ? 32'h0 : model_load(mem[idx], a, sz, sgn);
        if (we)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[idx][8*b +: 8] = wrep[8*b +: 8];
        #1 check("ack_stall", mem_stall, 0);
        @(posedge clk); #1;
        d_ack = 0;
        drive_idle();
        check("done_req", d_req, 0);
        check("done_rw", RegWrite_out, rw);
        check("done_m2r", MemtoReg_out, m2r);
        check("done_alu", Aluout_out, a);
        check("done_rd", rd_out, dst);
        check("done_rdata", rdata_out, exp_rd);
        check("stall_cycles", stalls, delay + 1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        reset = 0; d_ack = 0; d_rdata = 0;
        drive_idle();
        in_valid = 1; MemRead = 1;
        #12;
        check("rst_stall", mem_stall, 0);
        check("rst_req", d_req, 0);
        check("rst_addr", d_addr, 0);
        check("rst_rw", RegWrite_out, 0);
        check("rst_bad", bad_addr, 0);
        drive_idle();
        reset = 1;
        @(posedge clk); #1;

        alu_op(32'h1234, 5'd5, 1, 1);
        mem[64] = 32'hDEADBEEF;
        mem_op(1, 0, 2'd2, 0, 32'h100, 0, 5'd7, 1, 1, 2);
        mem[64] = 32'h80112233;
        mem_op(1, 0, 2'd0, 1, 32'h103, 0, 5'd8, 1, 1, 0);
        mem_op(1, 0, 2'd1, 0, 32'h102, 0, 5'd9, 1, 1, 1);
        mem_op(0, 1, 2'd0, 0, 32'h101, 32'hAB, 5'd0, 0, 0, 1);
        mem_op(0, 1, 2'd1, 0, 32'h102, 32'h5A5A, 5'd0, 0, 0, 0);
        mem_op(1, 0, 2'd2, 0, 32'h100, 0, 5'd10, 1, 1, 0);
        mem_op(1, 0, 2'd2, 0, 32'h102, 0, 5'd11, 1, 1, 0);
        mem_op(1, 1, 2'd3, 0, 32'h104, 32'hCAFEF00D, 5'd3, 0, 0, 1);
        mem_op(1, 0, 2'd3, 0, 32'h104, 0, 5'd12, 1, 1, 0);

        // Reset while a request is outstanding.
        drive_idle();
        in_valid = 1; MemRead = 1; size = 2'd2; Aluout = 32'h200; rd = 5'd4; RegWrite = 1;
        @(posedge clk); #1;
        check("pre_rst_req", d_req, 1);
        #2 reset = 0;
        #1;
        check("wrst_req", d_req, 0);
        check("wrst_stall", mem_stall, 0);
        check("wrst_addr", d_addr, 0);
        check("wrst_rw", RegWrite_out, 0);
        check("wrst_alu", Aluout_out, 0);
        check("wrst_bad", bad_addr, 0);
        drive_idle();
        reset = 1;
        @(posedge clk); #1;
        mem_op(1, 0, 2'd2, 0, 32'h200, 0, 5'd4, 1, 0, 1);

        for (int n = 0; n < 60; n++) begin
            int unsigned kind;
            logic [31:0] a;
            logic [1:0]  sz;
            kind = $urandom_range(0, 3);
            sz   = 2'($urandom_range(0, 3));
            a    = {22'd0, 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 3) != 0) a = a & ((sz == 2'd0) ? 32'hFFFFFFFF :
                                                    (sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFC);
            case (kind)
                0: alu_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom));
                1: mem_op(1, 0, sz, 1'($urandom), a, 0, 5'($urandom), 1, 1,
                          $urandom_range(0, 3));
                2: mem_op(0, 1, sz, 0, a, $urandom, 5'($urandom), 0, 0, $urandom_range(0, 3));
                default: mem_op(1, 1, sz, 0, a, $urandom, 5'($urandom), 1'($urandom), 0,
                                $urandom_range(0, 3));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
